// File: rtl/sample_jitter_pkg.sv
// Shared raster definitions for hash consumers and the sample jitter pipeline.
// Payload widths track the raster default coordinate and tag widths.
package sample_jitter_pkg;

    localparam int unsigned HASH_W         = 8;
    localparam int unsigned HASH_IN_W      = 40;
    localparam int unsigned RASTER_COORD_W = 24;
    localparam int unsigned RASTER_TAG_W   = 8;
    localparam int unsigned SHIFT_W        = 2;

    typedef struct packed {
        logic [RASTER_COORD_W-1:0] x;
        logic [RASTER_COORD_W-1:0] y;
        logic [RASTER_TAG_W-1:0]   tag;
        logic [HASH_W-1:0]         hash;
        logic [SHIFT_W-1:0]        shift;
    } stage_t;

endpackage

// File: rtl/jitter_hash_fold.sv
// Combinational 40->8 XOR fold with mask: low byte XOR top byte, then masked.
module jitter_hash_fold
    import sample_jitter_pkg::*;
(
    input  logic [HASH_IN_W-1:0] i_hin,
    input  logic [HASH_W-1:0]    i_mask,
    output logic [HASH_W-1:0]    o_hash
);

    // The middle bytes do not participate in this fold.
    logic w_unused_mid;
    assign w_unused_mid = ^i_hin[HASH_IN_W-HASH_W-1:HASH_W];

    assign o_hash = (i_hin[HASH_W-1:0] ^ i_hin[HASH_IN_W-1 -: HASH_W]) & i_mask;

endmodule

// File: rtl/sample_jitter.sv
// Two-stage valid/ready pipeline adding a hash-derived sub-pixel jitter to each sample.
// Stage 1 captures the sample and its hash; stage 2 holds the jittered result.
module sample_jitter
    import sample_jitter_pkg::*;
#(
    parameter int unsigned SIGFIG = RASTER_COORD_W,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned TAG_W  = RASTER_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIGFIG-1:0] in_x,
    input  logic [SIGFIG-1:0] in_y,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [7:0]        jitter_mask,
    input  logic [1:0]        jitter_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIGFIG-1:0] out_x,
    output logic [SIGFIG-1:0] out_y,
    output logic [TAG_W-1:0]  out_tag,
    output logic [7:0]        out_hash,
    output logic [15:0]       out_count
);

    logic [HASH_IN_W-1:0] w_hin;
    logic [HASH_W-1:0]    w_hash;
    stage_t               w_s1_d;
    stage_t               r_s1;
    logic                 r_v1;
    logic                 r_v2;
    logic [SIGFIG-1:0]    r_x2;
    logic [SIGFIG-1:0]    r_y2;
    logic [TAG_W-1:0]     r_tag2;
    logic [HASH_W-1:0]    r_hash2;
    logic [15:0]          r_count;
    logic                 w_s1_load;
    logic                 w_s2_load;
    logic [31:0]          w_amt;
    logic [SIGFIG-1:0]    w_off_x;
    logic [SIGFIG-1:0]    w_off_y;
    logic [SIGFIG-1:0]    w_sum_x;
    logic [SIGFIG-1:0]    w_sum_y;

    assign w_hin = {in_x[19:0], in_y[19:0]};

    jitter_hash_fold u_fold (
        .i_hin  (w_hin),
        .i_mask (jitter_mask),
        .o_hash (w_hash)
    );

    always_comb begin
        w_s1_d       = '0;
        w_s1_d.x     = RASTER_COORD_W'(in_x);
        w_s1_d.y     = RASTER_COORD_W'(in_y);
        w_s1_d.tag   = RASTER_TAG_W'(in_tag);
        w_s1_d.hash  = w_hash;
        w_s1_d.shift = jitter_shift;
    end

    // Stall path is combinational from out_ready; depth is only two registers.
    assign w_s2_load = !r_v2 || out_ready;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_s1_load) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1_d;
            end
        end
    end

    assign w_amt   = RADIX - 32'd4 - 32'(r_s1.shift);
    assign w_off_x = SIGFIG'(r_s1.hash[3:0]) << w_amt;
    assign w_off_y = SIGFIG'(r_s1.hash[7:4]) << w_amt;
    assign w_sum_x = SIGFIG'(r_s1.x) + w_off_x;
    assign w_sum_y = SIGFIG'(r_s1.y) + w_off_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_x2    <= '0;
            r_y2    <= '0;
            r_tag2  <= '0;
            r_hash2 <= '0;
        end else if (w_s2_load) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_x2    <= w_sum_x;
                r_y2    <= w_sum_y;
                r_tag2  <= TAG_W'(r_s1.tag);
                r_hash2 <= r_s1.hash;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_v2 && out_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_valid = r_v2;
    assign out_x     = r_x2;
    assign out_y     = r_y2;
    assign out_tag   = r_tag2;
    assign out_hash  = r_hash2;
    assign out_count = r_count;

endmodule

// File: tb/tb_sample_jitter.sv
// Directed bench for sample_jitter: vector table, backpressure stream, mid-stream reset.
module tb_sample_jitter;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int TAG_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SIGFIG-1:0] in_x;
    logic [SIGFIG-1:0] in_y;
    logic [TAG_W-1:0]  in_tag;
    logic [7:0]        jitter_mask;
    logic [1:0]        jitter_shift;
    logic              out_valid;
    logic              out_ready;
    logic [SIGFIG-1:0] out_x;
    logic [SIGFIG-1:0] out_y;
    logic [TAG_W-1:0]  out_tag;
    logic [7:0]        out_hash;
    logic [15:0]       out_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sample_jitter #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .TAG_W  (TAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_tag       (in_tag),
        .jitter_mask  (jitter_mask),
        .jitter_shift (jitter_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_tag      (out_tag),
        .out_hash     (out_hash),
        .out_count    (out_count)
    );

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic [7:0]  mask;
        logic [1:0]  shift;
        logic [7:0]  tag;
        logic [7:0]  exp_h;
        logic [23:0] exp_x;
        logic [23:0] exp_y;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit seen;
        @(negedge clk);
        in_valid     = 1'b1;
        in_x         = v.x;
        in_y         = v.y;
        in_tag       = v.tag;
        jitter_mask  = v.mask;
        jitter_shift = v.shift;
        out_ready    = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the in-flight sample must not change.
        in_valid     = 1'b0;
        in_x         = 24'(~v.x);
        in_y         = 24'(~v.y);
        in_tag       = 8'(~v.tag);
        jitter_mask  = ~v.mask;
        jitter_shift = ~v.shift;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
        check($sformatf("v%0d_hash", idx), 32'(out_hash), 32'(v.exp_h));
        check($sformatf("v%0d_x", idx), 32'(out_x), 32'(v.exp_x));
        check($sformatf("v%0d_y", idx), 32'(out_y), 32'(v.exp_y));
        check($sformatf("v%0d_tag", idx), 32'(out_tag), 32'(v.tag));
    endtask

    initial begin
        int sent;
        int recv;
        int occ;
        int stall_seen;
        int ghost;
        logic [23:0] bx[10];
        logic [23:0] by[10];

        vecs[0] = '{24'h05A000, 24'h000033, 8'hFF, 2'd0, 8'h01, 8'h69, 24'h05A240, 24'h0001B3};
        vecs[1] = '{24'h05A000, 24'h000033, 8'hFF, 2'd2, 8'h02, 8'h69, 24'h05A090, 24'h000093};
        vecs[2] = '{24'h05A000, 24'h000033, 8'h0F, 2'd0, 8'h03, 8'h09, 24'h05A240, 24'h000033};
        vecs[3] = '{24'hFFFFFF, 24'h000000, 8'hFF, 2'd0, 8'h04, 8'hFF, 24'h0003BF, 24'h0003C0};
        vecs[4] = '{24'h000000, 24'h000000, 8'hFF, 2'd3, 8'h05, 8'h00, 24'h000000, 24'h000000};
        vecs[5] = '{24'h0AB000, 24'h0000CD, 8'hFF, 2'd1, 8'h06, 8'h66, 24'h0AB0C0, 24'h00018D};
        vecs[6] = '{24'h123456, 24'h789ABC, 8'hF0, 2'd3, 8'h07, 8'h90, 24'h123456, 24'h789B04};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        in_tag       = '0;
        jitter_mask  = 8'hFF;
        jitter_shift = 2'd0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_hash", 32'(out_hash), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end
        @(negedge clk);
        check("table_count", 32'(out_count), 32'd7);
        check("table_idle", 32'(out_valid), 32'd0);

        // Backpressure stream; mask 0 means outputs equal inputs.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bx[i] = 24'h010000 * 24'(i) + 24'h000123;
            by[i] = 24'h00AB00 + 24'(i);
        end
        jitter_mask  = 8'h00;
        jitter_shift = 2'd0;
        sent       = 0;
        recv       = 0;
        stall_seen = 0;
        for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
            @(negedge clk);
            occ       = sent - recv;
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_x     = bx[sent];
                in_y     = by[sent];
                in_tag   = 8'(8'h20 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(in_ready), (occ == 2 && !out_ready) ? 32'd0 : 32'd1);
            if (!in_ready) stall_seen++;
            if (out_valid && recv < 10) begin
                check("bp_tag", 32'(out_tag), 32'(8'h20 + recv));
                check("bp_x", 32'(out_x), 32'(bx[recv]));
                check("bp_y", 32'(out_y), 32'(by[recv]));
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp_delivered", 32'(recv), 32'd10);
        check("bp_in_ready_dropped", 32'(stall_seen > 0), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_count", 32'(out_count), 32'd10);
        check("bp_idle", 32'(out_valid), 32'd0);

        // Two samples in flight, then a one-cycle reset.
        out_ready    = 1'b0;
        jitter_mask  = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 24'h0AA000 + 24'(i);
            in_y     = 24'h000055;
            in_tag   = 8'(8'hE0 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_count", 32'(out_count), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        ghost     = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("mid_no_ghost", 32'(ghost), 32'd0);
        check("mid_final_count", 32'(out_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
